// File: rtl/array_event_arbiter_if.sv
// Event/issue bundle between the event sources, the arbiter and the counter array.
// Pure wiring; adds no latency.
// No backpressure: events are accepted every cycle, issues are fire-and-forget.
interface array_event_arbiter_if #(
   parameter int N   = 8,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   inc_req;
   logic [N-1:0]   dec_req;
   logic           ovf_clr;
   logic           inc;
   logic [IDW-1:0] inc_id;
   logic           dec;
   logic [IDW-1:0] dec_id;
   logic [N-1:0]   ovf;
   logic           busy;

   // event source / bench side
   modport master (
      output inc_req, dec_req, ovf_clr,
      input  inc, inc_id, dec, dec_id, ovf, busy
   );

   // arbiter side
   modport slave (
      input  inc_req, dec_req, ovf_clr,
      output inc, inc_id, dec, dec_id, ovf, busy
   );
endinterface

// File: rtl/array_event_arbiter.sv
// One direction (inc or dec): per-ID saturating pending counters plus a round-robin issuer.
// Request in cycle 0 -> pending in cycle 1 -> issue registered, visible in cycle 2.
// No backpressure: a request arriving on a saturated counter that is not granted is dropped.
module array_event_arbiter_path #(
   parameter int N   = 8,
   parameter int PW  = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic           issue,
   output logic [IDW-1:0] issue_id,
   output logic [N-1:0]   drop,
   output logic           any_pend_nxt
);

   localparam logic [PW-1:0]  PEND_MAX = '1;
   localparam logic [PW-1:0]  PEND_ONE = PW'(1);
   localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);
   localparam logic [N-1:0]   ONEHOT0  = N'(1);

   logic [PW-1:0]  pend     [N];
   logic [PW-1:0]  pend_nxt [N];
   logic [IDW-1:0] ptr;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   logic [N-1:0]   grant;

   // (base + k) mod N without relying on N being a power of two
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N) s = s - N;
      return IDW'(s);
   endfunction

   // Round-robin search over registered pending counts, starting at ptr
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = 0; k < N; k++) begin
         if (!gnt_vld && (pend[wrap_add(ptr, k)] != '0)) begin
            gnt_vld = 1'b1;
            gnt_id  = wrap_add(ptr, k);
         end
      end
      grant = gnt_vld ? (ONEHOT0 << gnt_id) : '0;
   end

   // Pending update: +req -grant, holding at the ceiling and flagging the lost event
   always_comb begin
      any_pend_nxt = 1'b0;
      for (int i = 0; i < N; i++) begin
         pend_nxt[i] = pend[i];
         drop[i]     = 1'b0;
         if (req[i] && !grant[i]) begin
            if (pend[i] == PEND_MAX) drop[i] = 1'b1;
            else                     pend_nxt[i] = pend[i] + PEND_ONE;
         end else if (!req[i] && grant[i]) begin
            pend_nxt[i] = pend[i] - PEND_ONE;
         end
         if (pend_nxt[i] != '0) any_pend_nxt = 1'b1;
      end
   end

   // State and registered issue; the pointer only moves past a winner
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) pend[i] <= '0;
         ptr      <= '0;
         issue    <= 1'b0;
         issue_id <= '0;
      end else begin
         for (int i = 0; i < N; i++) pend[i] <= pend_nxt[i];
         issue    <= gnt_vld;
         issue_id <= gnt_id;
         if (gnt_vld) ptr <= (gnt_id == ID_LAST) ? '0 : gnt_id + ID_ONE;
      end
   end

endmodule

// Feeds an N-entry up/down counter array one inc and one dec per cycle from bursty per-ID events.
// Two-cycle latency from event to issue; throughput one inc plus one dec per cycle.
// No backpressure: events beyond 2**PW-1 queued per ID/direction are dropped and flagged in ovf.
module array_event_arbiter #(
   parameter int N   = 8,
   parameter int PW  = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   array_event_arbiter_if.slave bus
);

   logic [N-1:0] inc_drop;
   logic [N-1:0] dec_drop;
   logic         inc_any;
   logic         dec_any;

   array_event_arbiter_path #(.N(N), .PW(PW), .IDW(IDW)) u_inc (
      .clk          (clk),
      .rst          (rst),
      .req          (bus.inc_req),
      .issue        (bus.inc),
      .issue_id     (bus.inc_id),
      .drop         (inc_drop),
      .any_pend_nxt (inc_any)
   );

   array_event_arbiter_path #(.N(N), .PW(PW), .IDW(IDW)) u_dec (
      .clk          (clk),
      .rst          (rst),
      .req          (bus.dec_req),
      .issue        (bus.dec),
      .issue_id     (bus.dec_id),
      .drop         (dec_drop),
      .any_pend_nxt (dec_any)
   );

   // Sticky overflow (a new drop beats a clear) and busy from post-update pending state
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ovf  <= '0;
         bus.busy <= 1'b0;
      end else begin
         bus.ovf  <= (bus.ovf & ~{N{bus.ovf_clr}}) | inc_drop | dec_drop;
         bus.busy <= inc_any | dec_any;
      end
   end

endmodule

// File: tb/tb_array_event_arbiter.sv
// Bench for array_event_arbiter: queue-based reference model feeding a scoreboard,
// directed scenarios plus randomized traffic.
module tb_array_event_arbiter;
   localparam int N    = 8;
   localparam int PW   = 4;
   localparam int PMAX = (1 << PW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   array_event_arbiter_if #(.N(N)) bus();

   array_event_arbiter #(.N(N), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int           cyc;
      bit           inc;
      int           inc_id;
      bit           dec;
      int           dec_id;
      logic [N-1:0] ovf;
      bit           busy;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // reference state: number of queued events per direction and ID, plus rotation start
   int           m_pend [2][N];
   int           m_ptr  [2];
   logic [N-1:0] m_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One direction for one clock: pick the first ID with queued events, rotating from the
   // ID after the last winner, then apply arrivals/departures with a ceiling of PMAX.
   function automatic void path_step(input int d, input logic [N-1:0] req,
                                     output bit v, output int id, output logic [N-1:0] drop);
      v = 0; id = 0; drop = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr[d] + k) % N;
         if (!v && m_pend[d][j] > 0) begin v = 1; id = j; end
      end
      if (v) m_ptr[d] = (id + 1) % N;
      for (int i = 0; i < N; i++) begin
         int n;
         n = m_pend[d][i] + int'(req[i]) - ((v && id == i) ? 1 : 0);
         if (n > PMAX) begin n = PMAX; drop[i] = 1'b1; end
         m_pend[d][i] = n;
      end
   endfunction

   // Drive one cycle of inputs and queue what the DUT must show after the next edge
   task automatic step(input logic r, input logic [N-1:0] ir, input logic [N-1:0] dr, input logic c);
      exp_t e;
      bit vi, vd;
      int ii, id;
      logic [N-1:0] di, dd;
      @(posedge clk);
      #1;
      rst = r; bus.inc_req = ir; bus.dec_req = dr; bus.ovf_clr = c;
      e.cyc = cyc + 1;
      if (r) begin
         for (int i = 0; i < N; i++) begin m_pend[0][i] = 0; m_pend[1][i] = 0; end
         m_ptr[0] = 0; m_ptr[1] = 0; m_ovf = '0;
         e.inc = 0; e.inc_id = 0; e.dec = 0; e.dec_id = 0; e.ovf = '0; e.busy = 0;
      end else begin
         path_step(0, ir, vi, ii, di);
         path_step(1, dr, vd, id, dd);
         m_ovf = (c ? '0 : m_ovf) | di | dd;
         e.inc = vi; e.inc_id = ii; e.dec = vd; e.dec_id = id; e.ovf = m_ovf;
         e.busy = 0;
         for (int i = 0; i < N; i++)
            if (m_pend[0][i] != 0 || m_pend[1][i] != 0) e.busy = 1;
      end
      sb.push_back(e);
   endtask

   task automatic do_reset();
      step(1'b1, N'($urandom), N'($urandom), 1'b0);
      step(1'b1, N'($urandom), N'($urandom), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: compare every expected entry against the DUT mid-cycle after its edge
   initial begin
      forever begin
         @(posedge clk);
         #3;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) chk("sb_stale", 32'(e.cyc), 32'(cyc));
            chk("inc",    32'(bus.inc),    32'(e.inc));
            chk("inc_id", 32'(bus.inc_id), 32'(e.inc_id));
            chk("dec",    32'(bus.dec),    32'(e.dec));
            chk("dec_id", 32'(bus.dec_id), 32'(e.dec_id));
            chk("ovf",    32'(bus.ovf),    32'(e.ovf));
            chk("busy",   32'(bus.busy),   32'(e.busy));
         end
      end
   end

   initial begin
      logic [N-1:0] ir, dr;
      bus.inc_req = '0; bus.dec_req = '0; bus.ovf_clr = 1'b0;

      // T1: reset with random requests, then idle
      do_reset();
      step(1'b0, '0, '0, 1'b0);
      chk("t1_rst_inc",  32'(bus.inc),  0);
      chk("t1_rst_ovf",  32'(bus.ovf),  0);
      chk("t1_rst_busy", 32'(bus.busy), 0);
      idle(3);
      chk("t1_idle_busy", 32'(bus.busy), 0);
      chk("t1_idle_inc",  32'(bus.inc),  0);

      // T2: single event on ID 3
      do_reset();
      step(1'b0, 8'h08, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("t2_c1_busy", 32'(bus.busy), 1);
      chk("t2_c1_inc",  32'(bus.inc),  0);
      step(1'b0, '0, '0, 1'b0);
      chk("t2_c2_inc",    32'(bus.inc),    1);
      chk("t2_c2_inc_id", 32'(bus.inc_id), 3);
      chk("t2_c2_busy",   32'(bus.busy),   0);
      step(1'b0, '0, '0, 1'b0);
      chk("t2_c3_inc", 32'(bus.inc), 0);

      // T3: all IDs at once drain in ascending order
      do_reset();
      step(1'b0, 8'hFF, '0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         step(1'b0, '0, '0, 1'b0);
         if (c >= 2 && c <= 9) begin
            chk("t3_inc",    32'(bus.inc),    1);
            chk("t3_inc_id", 32'(bus.inc_id), 32'(c - 2));
         end
      end
      chk("t3_c10_inc", 32'(bus.inc), 0);
      chk("t3_ovf",     32'(bus.ovf), 0);

      // T4: two IDs held high alternate and eventually overflow
      do_reset();
      for (int c = 0; c < 40; c++) begin
         step(1'b0, 8'h22, '0, 1'b0);
         if (c >= 2 && c <= 5) chk("t4_alt_id", 32'(bus.inc_id), (c % 2 == 0) ? 1 : 5);
      end
      chk("t4_ovf_set", 32'(bus.ovf), 32'h22);
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);
      chk("t4_ovf_clr", 32'(bus.ovf), 0);
      idle(20);

      // T5a: same ID on both paths
      do_reset();
      step(1'b0, 8'h04, 8'h04, 1'b0);
      idle(1);
      step(1'b0, '0, '0, 1'b0);
      chk("t5a_inc",    32'(bus.inc),    1);
      chk("t5a_dec",    32'(bus.dec),    1);
      chk("t5a_inc_id", 32'(bus.inc_id), 2);
      chk("t5a_dec_id", 32'(bus.dec_id), 2);

      // T5b: dec sees IDs 0,2,7 while inc sees 2
      do_reset();
      step(1'b0, 8'h04, 8'h85, 1'b0);
      idle(1);
      for (int c = 2; c <= 4; c++) begin
         step(1'b0, '0, '0, 1'b0);
         chk("t5b_dec",    32'(bus.dec),    1);
         chk("t5b_dec_id", 32'(bus.dec_id), (c == 2) ? 0 : (c == 3) ? 2 : 7);
         if (c == 2) chk("t5b_inc_id", 32'(bus.inc_id), 2);
      end

      // T6: reset in the middle of a burst discards everything
      do_reset();
      step(1'b0, 8'hFF, '0, 1'b0);
      idle(2);
      step(1'b1, '0, '0, 1'b0);
      for (int c = 4; c <= 8; c++) begin
         step(1'b0, '0, '0, 1'b0);
         chk("t6_inc",  32'(bus.inc),  0);
         chk("t6_busy", 32'(bus.busy), 0);
      end

      // Random traffic with varying density, occasional clears and rare resets
      for (int blk = 0; blk < 16; blk++) begin
         int dens;
         dens = $urandom_range(0, 3);
         for (int c = 0; c < 150; c++) begin
            ir = N'($urandom);
            dr = N'($urandom);
            for (int k = 0; k < dens; k++) begin
               ir = ir & N'($urandom);
               dr = dr & N'($urandom);
            end
            step(($urandom_range(0, 399) == 0), ir, dr, ($urandom_range(0, 19) == 0));
         end
      end
      idle(40);

      repeat (3) @(posedge clk);
      #4;
      chk("sb_drained", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
